mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory port between instruction fetch (IF requester) and load/store (LS requester, MEM stage).
- Sequences one transaction at a time: select, issue, wait for response, return the response to the owner.
- LS has priority. A starvation guard forces an IF grant after a bounded number of back-to-back LS grants.
- Sits between ifu/mem and the memory model; ifu stalls the pipeline while waiting on if_rvalid.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
STARVE_LIMIT, 4, consecutive LS grants with IF pending before IF is forced; 0 = strict LS priority, guard disabled

Ports:
sys_clk  in  1  clock, rising edge
sys_rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request; held with payload until if_ack
if_addr  in  ADDR_W  fetch address
if_ack  out  1  one-cycle pulse: IF request accepted
if_rvalid  out  1  one-cycle pulse: fetch data valid
if_rdata  out  DATA_W  fetch data
ls_req  in  1  load/store request; held until ls_ack
ls_we  in  1  1 = store
ls_addr  in  ADDR_W  data address
ls_wdata  in  DATA_W  store data
ls_wmask  in  DATA_W/8  byte write mask
ls_ack  out  1  one-cycle pulse: LS request accepted
ls_rvalid  out  1  one-cycle pulse: load data valid, or store complete
ls_rdata  out  DATA_W  load data (0 for stores)
mem_req  out  1  memory request; held until mem_gnt
mem_we, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  registered payload
mem_gnt  in  1  memory accepted request
mem_rvalid  in  1  memory response valid (reads and writes)
mem_rdata  in  DATA_W  memory read data
busy  out  1  state != IDLE

Behaviour:
- Interface fixed: one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: state=IDLE; owner=IF; streak=0; every output 0, including the mem_* payload and the rdata outputs.
- Reset mid-transaction: return to IDLE. A later mem_rvalid for the aborted transaction is ignored.
- States:
  - IDLE -> ISSUE: when if_req|ls_req. Arbitrate, latch owner and payload into mem_* registers, pulse the winner's *_ack in this cycle. IF payload uses mem_we=0, mem_wmask=0, mem_wdata=0.
  - ISSUE: mem_req=1, payload stable.
    - mem_gnt & mem_rvalid in the same cycle -> COMPLETE path straight to IDLE.
    - mem_gnt only -> WAIT. mem_req drops the next cycle.
  - WAIT: on mem_rvalid, pulse the owner's *_rvalid for 1 cycle and drive *_rdata = mem_rdata (ls_rdata=0 for a store) -> IDLE.
  - *_rdata holds its value until the next *_rvalid of the same requester.
- Minimum occupancy: 2 cycles with same-cycle gnt+rvalid, else 3+. A new request can be accepted in the cycle after completion.
- Arbitration in IDLE:
  - Only one requester -> it wins.
  - Both -> LS wins, unless STARVE_LIMIT!=0 and streak==STARVE_LIMIT, then IF wins.
- streak:
  - +1 on an LS grant while if_req=1; saturates at STARVE_LIMIT.
  - Cleared on an IF grant, or on an LS grant with if_req=0.
- Request withdrawn in IDLE before ack: allowed, no transaction.
- *_req and payload are ignored outside IDLE.
- mem_rvalid in IDLE, or in ISSUE without mem_gnt: protocol error, ignored, no state change.
- *_ack and *_rvalid are never asserted to both requesters in the same cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_if_wait [31:0] and perf_ls_wait [31:0].
  - Each increments every cycle its *_req=1 and its *_ack=0.
  - Saturate at 32'hFFFF_FFFF; reset to 0 by sys_rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then IF read: if_req=1, if_addr=64'h8000_0000; mem_gnt after 1 cycle, mem_rvalid=1 2 cycles later with mem_rdata=64'h0000_0013 -> if_ack at cycle 0, mem_addr=64'h8000_0000, if_rvalid pulses once with if_rdata=64'h13, busy=0 the following cycle.
- Simultaneous requests, STARVE_LIMIT=4, both held continuously, zero-latency memory -> grant order LS,LS,LS,LS,IF,LS,...; streak returns to 0 after the IF grant.
- Store: ls_we=1, ls_addr=64'h8000_0100, ls_wdata=64'hDEAD_BEEF, ls_wmask=8'h0F -> mem_* match for the whole ISSUE phase; ls_rvalid pulses with ls_rdata=0; if_rvalid stays 0.
- mem_gnt held low 5 cycles -> mem_req and payload stable all 5 cycles; no *_rvalid; busy=1 throughout.
- sys_rst asserted in WAIT, then a stale mem_rvalid=1 -> all outputs 0, stale response dropped, next if_req serviced normally.
- ARB_PERF_CNT_EN defined: if_req held 3 cycles while an LS transaction occupies the port -> perf_if_wait=3.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / load-store) for one single-ported memory.
// Optional wait-cycle counters are enabled with the ARB_PERF_CNT_EN macro.
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,

    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [DATA_W-1:0]     ls_wdata,
    input  logic [DATA_W/8-1:0]   ls_wmask,
    output logic                  ls_ack,
    output logic                  ls_rvalid,
    output logic [DATA_W-1:0]     ls_rdata,

    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,

`ifdef ARB_PERF_CNT_EN
    output logic [31:0]           perf_if_wait,
    output logic [31:0]           perf_ls_wait,
`endif
    output logic                  busy
);

    localparam int MW = DATA_W / 8;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q;
    logic                owner_ls_q;
    logic [SW-1:0]       streak_q;
    logic [SW-1:0]       streak_d;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MW-1:0]       mem_wmask_q;
    logic                if_rvalid_q;
    logic                ls_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q;
    logic [DATA_W-1:0]   ls_rdata_q;

    logic                idle_c;
    logic                force_if_c;
    logic                gnt_ls_c;
    logic                gnt_if_c;
    logic                done_c;

    // Saturating count of LS wins taken while IF was left waiting.
    function automatic logic [SW-1:0] streak_next(input logic [SW-1:0] s,
                                                  input logic          ls_win,
                                                  input logic          if_pending);
        if (ls_win && if_pending) begin
            return (s == LIMIT) ? s : s + SW'(1);
        end
        return '0;
    endfunction

    assign idle_c     = (state_q == S_IDLE) && !sys_rst;
    assign force_if_c = (STARVE_LIMIT != 0) && (streak_q == LIMIT);
    assign gnt_ls_c   = idle_c && ls_req && !(if_req && force_if_c);
    assign gnt_if_c   = idle_c && if_req && !gnt_ls_c;
    assign streak_d   = streak_next(streak_q, gnt_ls_c, if_req);

    // A response only counts once the request has been granted by memory.
    assign done_c = ((state_q == S_ISSUE) && mem_gnt && mem_rvalid) ||
                    ((state_q == S_WAIT) && mem_rvalid);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= S_IDLE;
            owner_ls_q  <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (gnt_ls_c || gnt_if_c) begin
                        state_q    <= S_ISSUE;
                        mem_req_q  <= 1'b1;
                        owner_ls_q <= gnt_ls_c;
                        streak_q   <= streak_d;
                        if (gnt_ls_c) begin
                            mem_we_q    <= ls_we;
                            mem_addr_q  <= ls_addr;
                            mem_wdata_q <= ls_wdata;
                            mem_wmask_q <= ls_wmask;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= mem_rvalid ? S_IDLE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase

            if (done_c) begin
                if (owner_ls_q) begin
                    ls_rvalid_q <= 1'b1;
                    ls_rdata_q  <= mem_we_q ? '0 : mem_rdata;
                end else begin
                    if_rvalid_q <= 1'b1;
                    if_rdata_q  <= mem_rdata;
                end
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q;
    logic [31:0] perf_ls_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            perf_if_q <= '0;
            perf_ls_q <= '0;
        end else begin
            if (if_req && !if_ack && (perf_if_q != 32'hFFFF_FFFF)) begin
                perf_if_q <= perf_if_q + 32'd1;
            end
            if (ls_req && !ls_ack && (perf_ls_q != 32'hFFFF_FFFF)) begin
                perf_ls_q <= perf_ls_q + 32'd1;
            end
        end
    end

    assign perf_if_wait = perf_if_q;
    assign perf_ls_wait = perf_ls_q;
`endif

    assign if_ack    = gnt_if_c;
    assign ls_ack    = gnt_ls_c;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign busy      = (state_q != S_IDLE);

endmodule
